// File: rtl/br_resolve.sv
`default_nettype none
// ============================================================================
// Module  : br_resolve
// Brief   : Tracks IF-predicted branch metadata to EX, resolves mispredicts,
//           emits BTB updates, a one-cycle redirect/flush pulse and counters.
// Revision: 1.0 - initial release
// ============================================================================
module br_resolve (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_pc_i,
  input  logic [2:0]  ex_op_i,
  input  logic        ex_br_comp_i,
  input  logic [31:0] ex_target_i,
  output logic [2:0]  btb_op_o,
  output logic        btb_br_comp_o,
  output logic [31:0] btb_pc_predict_write_o,
  output logic [13:0] btb_im_address_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic [15:0] mispredict_cnt_o,
  output logic [15:0] branch_cnt_o
);

  localparam logic [2:0]  C_OP_BR   = 3'b110;
  localparam logic [2:0]  C_OP_NONE = 3'b000;
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RECOVER = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic        r_id_pred_taken;
  logic [31:0] r_id_pred_pc;
  logic        r_ex_valid;
  logic [31:0] r_ex_pc;
  logic        r_ex_pred_taken;
  logic [31:0] r_ex_pred_pc;

  logic [2:0]  r_btb_op;
  logic        r_btb_br_comp;
  logic [31:0] r_btb_pc;
  logic [13:0] r_btb_addr;
  logic [31:0] r_redirect_pc;
  logic [15:0] r_mis_cnt;
  logic [15:0] r_br_cnt;

  logic        w_resolve;
  logic        w_is_br;
  logic        w_taken;
  logic        w_mispredict;
  logic [31:0] w_correct_pc;

  assign w_is_br      = (ex_op_i == C_OP_BR);
  assign w_resolve    = r_ex_valid & ~stall_i & (r_state == S_IDLE);
  assign w_taken      = w_is_br & ex_br_comp_i;
  assign w_correct_pc = w_taken ? ex_target_i : (r_ex_pc + 32'd4);

  // A non-branch that hit in the BTB as taken is a false hit.
  always_comb begin
    w_mispredict = 1'b0;
    if (w_resolve) begin
      if (w_is_br) begin
        w_mispredict = (ex_br_comp_i != r_ex_pred_taken) |
                       (w_taken & r_ex_pred_taken & (r_ex_pred_pc != ex_target_i));
      end else begin
        w_mispredict = r_ex_pred_taken;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_mispredict) w_state_next = S_RECOVER;
      S_RECOVER: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Flush wins over stall: recovery empties both slots and drops the IF capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_valid      <= 1'b0;
      r_id_pc         <= 32'd0;
      r_id_pred_taken <= 1'b0;
      r_id_pred_pc    <= 32'd0;
      r_ex_valid      <= 1'b0;
      r_ex_pc         <= 32'd0;
      r_ex_pred_taken <= 1'b0;
      r_ex_pred_pc    <= 32'd0;
    end else if (r_state == S_RECOVER) begin
      r_id_valid <= 1'b0;
      r_ex_valid <= 1'b0;
    end else if (!stall_i) begin
      r_id_valid      <= if_valid_i;
      r_id_pc         <= if_pc_i;
      r_id_pred_taken <= pred_taken_i;
      r_id_pred_pc    <= pred_pc_i;
      r_ex_valid      <= r_id_valid;
      r_ex_pc         <= r_id_pc;
      r_ex_pred_taken <= r_id_pred_taken;
      r_ex_pred_pc    <= r_id_pred_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_btb_op      <= C_OP_NONE;
      r_btb_br_comp <= 1'b0;
      r_btb_pc      <= 32'd0;
      r_btb_addr    <= 14'd0;
      r_redirect_pc <= 32'd0;
      r_mis_cnt     <= 16'd0;
      r_br_cnt      <= 16'd0;
    end else begin
      r_btb_op <= C_OP_NONE;
      if (w_resolve & w_is_br) begin
        r_btb_op      <= C_OP_BR;
        r_btb_br_comp <= ex_br_comp_i;
        r_btb_pc      <= ex_target_i;
        r_btb_addr    <= r_ex_pc[13:0];
        if (r_br_cnt != C_CNT_MAX) r_br_cnt <= r_br_cnt + 16'd1;
      end
      if (w_mispredict) begin
        r_redirect_pc <= w_correct_pc;
        if (r_mis_cnt != C_CNT_MAX) r_mis_cnt <= r_mis_cnt + 16'd1;
      end
    end
  end

  assign btb_op_o               = r_btb_op;
  assign btb_br_comp_o          = r_btb_br_comp;
  assign btb_pc_predict_write_o = r_btb_pc;
  assign btb_im_address_o       = r_btb_addr;
  assign redirect_o             = (r_state == S_RECOVER);
  assign flush_o                = (r_state == S_RECOVER);
  assign redirect_pc_o          = r_redirect_pc;
  assign mispredict_cnt_o       = r_mis_cnt;
  assign branch_cnt_o           = r_br_cnt;

endmodule
`default_nettype wire

// File: tb/tb_br_resolve.sv
`default_nettype none
// ============================================================================
// Module  : tb_br_resolve
// Brief   : Directed and randomized checks of br_resolve against a
//           transaction-level model of the branch resolution rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_br_resolve;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic        pred_taken_i;
  logic [31:0] pred_pc_i;
  logic [2:0]  ex_op_i;
  logic        ex_br_comp_i;
  logic [31:0] ex_target_i;
  logic [2:0]  btb_op_o;
  logic        btb_br_comp_o;
  logic [31:0] btb_pc_predict_write_o;
  logic [13:0] btb_im_address_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic [15:0] mispredict_cnt_o;
  logic [15:0] branch_cnt_o;

  always #5 clk_i = ~clk_i;

  br_resolve dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .stall_i                (stall_i),
    .if_valid_i             (if_valid_i),
    .if_pc_i                (if_pc_i),
    .pred_taken_i           (pred_taken_i),
    .pred_pc_i              (pred_pc_i),
    .ex_op_i                (ex_op_i),
    .ex_br_comp_i           (ex_br_comp_i),
    .ex_target_i            (ex_target_i),
    .btb_op_o               (btb_op_o),
    .btb_br_comp_o          (btb_br_comp_o),
    .btb_pc_predict_write_o (btb_pc_predict_write_o),
    .btb_im_address_o       (btb_im_address_o),
    .redirect_o             (redirect_o),
    .redirect_pc_o          (redirect_pc_o),
    .flush_o                (flush_o),
    .mispredict_cnt_o       (mispredict_cnt_o),
    .branch_cnt_o           (branch_cnt_o)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ppc;
  } slot_t;

  // Reference model: in-flight instructions plus what each output should show.
  slot_t       m_id, m_ex;
  bit          m_recover;
  logic [2:0]  e_btb_op;
  logic        e_btb_comp;
  logic [31:0] e_btb_pc;
  logic [13:0] e_btb_addr;
  logic        e_redir;
  logic [31:0] e_redir_pc;
  logic [15:0] e_mis_cnt;
  logic [15:0] e_br_cnt;

  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    m_id = '0; m_ex = '0; m_recover = 1'b0;
    e_btb_op = 3'b000; e_btb_comp = 1'b0; e_btb_pc = '0; e_btb_addr = '0;
    e_redir = 1'b0; e_redir_pc = '0; e_mis_cnt = '0; e_br_cnt = '0;
  endfunction

  // Outcome of the coming clock edge, given the inputs currently applied.
  function automatic void model_edge();
    logic        br, mis;
    logic [31:0] next_pc;
    e_btb_op = 3'b000;
    e_redir  = 1'b0;
    if (m_recover) begin
      m_id.v = 1'b0; m_ex.v = 1'b0; m_recover = 1'b0;
      return;
    end
    if (stall_i) return;
    if (m_ex.v) begin
      br      = (ex_op_i == 3'b110);
      next_pc = (br && ex_br_comp_i) ? ex_target_i : m_ex.pc + 32'd4;
      if (br) mis = (ex_br_comp_i != m_ex.pt) || (ex_br_comp_i && m_ex.pt && (m_ex.ppc != ex_target_i));
      else    mis = m_ex.pt;
      if (br) begin
        e_btb_op = 3'b110; e_btb_comp = ex_br_comp_i; e_btb_pc = ex_target_i; e_btb_addr = m_ex.pc[13:0];
        if (e_br_cnt != 16'hFFFF) e_br_cnt = e_br_cnt + 16'd1;
      end
      if (mis) begin
        e_redir = 1'b1; e_redir_pc = next_pc; m_recover = 1'b1;
        if (e_mis_cnt != 16'hFFFF) e_mis_cnt = e_mis_cnt + 16'd1;
      end
    end
    m_ex = m_id;
    m_id = {if_valid_i, if_pc_i, pred_taken_i, pred_pc_i};
  endfunction

  task automatic drive(input logic st, input logic iv, input logic [31:0] pc, input logic pt,
                       input logic [31:0] ppc, input logic [2:0] op, input logic comp,
                       input logic [31:0] tgt);
    stall_i = st; if_valid_i = iv; if_pc_i = pc; pred_taken_i = pt; pred_pc_i = ppc;
    ex_op_i = op; ex_br_comp_i = comp; ex_target_i = tgt;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 32'h0, 3'b000, 0, 32'h0);
    tick();
  endtask

  // Fetch one instruction and carry it to EX, resolving it with the given EX result.
  task automatic run_branch(input logic [31:0] pc, input logic pt, input logic [31:0] ppc,
                            input logic [2:0] op, input logic comp, input logic [31:0] tgt);
    drive(0, 1, pc, pt, ppc, 3'b000, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, 3'b000, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0, op, comp, tgt);
    tick();
  endtask

  task automatic test_reset();
    drive(0, 0, 32'h0, 0, 32'h0, 3'b000, 0, 32'h0);
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    checks++; if (btb_op_o !== 3'b000) begin errors++; $display("FAIL reset btb_op: got %h expected 0", btb_op_o); end
    checks++; if ({redirect_o, flush_o} !== 2'b00) begin errors++; $display("FAIL reset redirect/flush: got %b expected 00", {redirect_o, flush_o}); end
    checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset redirect_pc: got %h expected 0", redirect_pc_o); end
    checks++; if ({mispredict_cnt_o, branch_cnt_o} !== 32'h0) begin errors++; $display("FAIL reset counters: got %h expected 0", {mispredict_cnt_o, branch_cnt_o}); end
    checks++; if ({btb_br_comp_o, btb_pc_predict_write_o, btb_im_address_o} !== 47'h0) begin errors++; $display("FAIL reset btb fields: got %h expected 0", {btb_br_comp_o, btb_pc_predict_write_o, btb_im_address_o}); end
    rst_ni = 1'b1;
  endtask

  task automatic test_not_taken();
    run_branch(32'h100, 0, 32'h0, 3'b110, 0, 32'h180);
    checks++; if (btb_op_o !== 3'b110) begin errors++; $display("FAIL nt btb_op: got %h expected 6", btb_op_o); end
    checks++; if (btb_br_comp_o !== 1'b0) begin errors++; $display("FAIL nt btb_comp: got %b expected 0", btb_br_comp_o); end
    checks++; if (btb_pc_predict_write_o !== 32'h180) begin errors++; $display("FAIL nt btb_pc: got %h expected 180", btb_pc_predict_write_o); end
    checks++; if (btb_im_address_o !== 14'h100) begin errors++; $display("FAIL nt btb_addr: got %h expected 100", btb_im_address_o); end
    checks++; if (branch_cnt_o !== 16'd1) begin errors++; $display("FAIL nt branch_cnt: got %0d expected 1", branch_cnt_o); end
    checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL nt redirect: got %b expected 0", redirect_o); end
    idle();
    checks++; if (btb_op_o !== 3'b000) begin errors++; $display("FAIL nt btb_op pulse: got %h expected 0", btb_op_o); end
    checks++; if (btb_pc_predict_write_o !== 32'h180) begin errors++; $display("FAIL nt btb_pc hold: got %h expected 180", btb_pc_predict_write_o); end
  endtask

  task automatic test_wrong_target();
    drive(0, 1, 32'h400, 1, 32'h200, 3'b000, 0, 32'h0); tick();
    drive(0, 1, 32'h404, 1, 32'h900, 3'b000, 0, 32'h0); tick();
    drive(0, 1, 32'h408, 1, 32'h900, 3'b110, 1, 32'h240); tick();
    checks++; if ({redirect_o, flush_o} !== 2'b11) begin errors++; $display("FAIL wt redirect/flush: got %b expected 11", {redirect_o, flush_o}); end
    checks++; if (redirect_pc_o !== 32'h240) begin errors++; $display("FAIL wt redirect_pc: got %h expected 240", redirect_pc_o); end
    checks++; if (mispredict_cnt_o !== 16'd1) begin errors++; $display("FAIL wt mispredict_cnt: got %0d expected 1", mispredict_cnt_o); end
    drive(0, 1, 32'h40C, 1, 32'h900, 3'b000, 0, 32'h0); tick();
    checks++; if ({redirect_o, flush_o} !== 2'b00) begin errors++; $display("FAIL wt pulse end: got %b expected 00", {redirect_o, flush_o}); end
    checks++; if (redirect_pc_o !== 32'h240) begin errors++; $display("FAIL wt redirect_pc hold: got %h expected 240", redirect_pc_o); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 32'h0, 0, 32'h0, 3'b000, 0, 32'h0); tick();
      checks++; if (redirect_o !== 1'b0 || mispredict_cnt_o !== 16'd1) begin errors++; $display("FAIL wt slots flushed %0d: redirect %b cnt %0d expected 0/1", i, redirect_o, mispredict_cnt_o); end
    end
  endtask

  task automatic test_taken_not();
    run_branch(32'h300, 1, 32'h380, 3'b110, 0, 32'h380);
    checks++; if (redirect_pc_o !== 32'h304) begin errors++; $display("FAIL tn redirect_pc: got %h expected 304", redirect_pc_o); end
    checks++; if (btb_br_comp_o !== 1'b0 || btb_op_o !== 3'b110) begin errors++; $display("FAIL tn btb: got comp %b op %h expected 0/6", btb_br_comp_o, btb_op_o); end
    checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL tn redirect: got %b expected 1", redirect_o); end
    idle();
  endtask

  task automatic test_false_hit();
    logic [15:0] mis0, br0;
    mis0 = e_mis_cnt; br0 = e_br_cnt;
    run_branch(32'hFFFF_FFFC, 1, 32'h800, 3'b000, 1, 32'h800);
    checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL fh redirect_pc wrap: got %h expected 0", redirect_pc_o); end
    checks++; if (btb_op_o !== 3'b000) begin errors++; $display("FAIL fh btb_op: got %h expected 0", btb_op_o); end
    checks++; if (mispredict_cnt_o !== mis0 + 16'd1) begin errors++; $display("FAIL fh mispredict_cnt: got %0d expected %0d", mispredict_cnt_o, mis0 + 16'd1); end
    checks++; if (branch_cnt_o !== br0) begin errors++; $display("FAIL fh branch_cnt: got %0d expected %0d", branch_cnt_o, br0); end
    idle();
  endtask

  task automatic test_stall();
    logic [15:0] br0;
    br0 = e_br_cnt;
    drive(0, 1, 32'h500, 1, 32'h600, 3'b000, 0, 32'h0); tick();
    drive(0, 0, 32'h0, 0, 32'h0, 3'b000, 0, 32'h0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h0, 0, 32'h0, 3'b110, 1, 32'h600); tick();
      checks++; if (btb_op_o !== 3'b000 || redirect_o !== 1'b0) begin errors++; $display("FAIL stall hold %0d: op %h redirect %b expected 0/0", i, btb_op_o, redirect_o); end
    end
    drive(0, 0, 32'h0, 0, 32'h0, 3'b110, 1, 32'h600); tick();
    checks++; if (btb_op_o !== 3'b110 || btb_im_address_o !== 14'h500) begin errors++; $display("FAIL stall release: op %h addr %h expected 6/500", btb_op_o, btb_im_address_o); end
    checks++; if (branch_cnt_o !== br0 + 16'd1 || redirect_o !== 1'b0) begin errors++; $display("FAIL stall release cnt: got %0d redirect %b expected %0d/0", branch_cnt_o, redirect_o, br0 + 16'd1); end
    drive(0, 0, 32'h0, 0, 32'h0, 3'b110, 1, 32'h600); tick();
    checks++; if (btb_op_o !== 3'b000 || branch_cnt_o !== br0 + 16'd1) begin errors++; $display("FAIL stall single: op %h cnt %0d expected 0/%0d", btb_op_o, branch_cnt_o, br0 + 16'd1); end
  endtask

  task automatic test_stall_recover();
    logic [15:0] mis0;
    mis0 = e_mis_cnt;
    drive(0, 1, 32'h700, 0, 32'h0, 3'b000, 0, 32'h0); tick();
    drive(0, 1, 32'h704, 1, 32'h900, 3'b000, 0, 32'h0); tick();
    drive(0, 1, 32'h708, 1, 32'h900, 3'b110, 1, 32'h780); tick();
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h780) begin errors++; $display("FAIL sr redirect: got %b pc %h expected 1/780", redirect_o, redirect_pc_o); end
    drive(1, 1, 32'h70C, 1, 32'h900, 3'b000, 0, 32'h0); tick();
    checks++; if (redirect_o !== 1'b0) begin errors++; $display("FAIL sr pulse end: got %b expected 0", redirect_o); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 32'h0, 0, 32'h0, 3'b000, 0, 32'h0); tick();
      checks++; if (redirect_o !== 1'b0 || mispredict_cnt_o !== mis0 + 16'd1) begin errors++; $display("FAIL sr slots cleared %0d: redirect %b cnt %0d expected 0/%0d", i, redirect_o, mispredict_cnt_o, mis0 + 16'd1); end
    end
  endtask

  task automatic test_saturate();
    force dut.r_mis_cnt = 16'hFFFE;
    force dut.r_br_cnt  = 16'hFFFE;
    #1;
    release dut.r_mis_cnt;
    release dut.r_br_cnt;
    e_mis_cnt = 16'hFFFE;
    e_br_cnt  = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      run_branch(32'hA00, 0, 32'h0, 3'b110, 1, 32'hB00);
      checks++; if (mispredict_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat mispredict_cnt %0d: got %h expected ffff", i, mispredict_cnt_o); end
      checks++; if (branch_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat branch_cnt %0d: got %h expected ffff", i, branch_cnt_o); end
      idle();
    end
  endtask

  task automatic test_reset_mid_recover();
    run_branch(32'hC00, 1, 32'hD00, 3'b110, 0, 32'hD00);
    checks++; if (redirect_o !== 1'b1) begin errors++; $display("FAIL rmr pre redirect: got %b expected 1", redirect_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if ({redirect_o, flush_o} !== 2'b00) begin errors++; $display("FAIL rmr async redirect/flush: got %b expected 00", {redirect_o, flush_o}); end
    checks++; if ({mispredict_cnt_o, branch_cnt_o, redirect_pc_o} !== 64'h0) begin errors++; $display("FAIL rmr async regs: got %h expected 0", {mispredict_cnt_o, branch_cnt_o, redirect_pc_o}); end
    checks++; if (btb_op_o !== 3'b000) begin errors++; $display("FAIL rmr async btb_op: got %h expected 0", btb_op_o); end
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if ({redirect_o, flush_o} !== 2'b00) begin errors++; $display("FAIL rmr post release %0d: got %b expected 00", i, {redirect_o, flush_o}); end
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int i = 0; i < 600; i++) begin
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      drive(1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 3) != 0),
            pc,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2000,
            ($urandom_range(0, 2) != 0) ? 3'b110 : 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2000);
      tick();
      checks++; if (btb_op_o !== e_btb_op) begin errors++; $display("FAIL rnd btb_op cyc %0d: got %h expected %h", i, btb_op_o, e_btb_op); end
      checks++; if (btb_br_comp_o !== e_btb_comp) begin errors++; $display("FAIL rnd btb_comp cyc %0d: got %b expected %b", i, btb_br_comp_o, e_btb_comp); end
      checks++; if (btb_pc_predict_write_o !== e_btb_pc) begin errors++; $display("FAIL rnd btb_pc cyc %0d: got %h expected %h", i, btb_pc_predict_write_o, e_btb_pc); end
      checks++; if (btb_im_address_o !== e_btb_addr) begin errors++; $display("FAIL rnd btb_addr cyc %0d: got %h expected %h", i, btb_im_address_o, e_btb_addr); end
      checks++; if (redirect_o !== e_redir || flush_o !== e_redir) begin errors++; $display("FAIL rnd redirect/flush cyc %0d: got %b%b expected %b", i, redirect_o, flush_o, e_redir); end
      checks++; if (redirect_pc_o !== e_redir_pc) begin errors++; $display("FAIL rnd redirect_pc cyc %0d: got %h expected %h", i, redirect_pc_o, e_redir_pc); end
      checks++; if (mispredict_cnt_o !== e_mis_cnt) begin errors++; $display("FAIL rnd mispredict_cnt cyc %0d: got %0d expected %0d", i, mispredict_cnt_o, e_mis_cnt); end
      checks++; if (branch_cnt_o !== e_br_cnt) begin errors++; $display("FAIL rnd branch_cnt cyc %0d: got %0d expected %0d", i, branch_cnt_o, e_br_cnt); end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    test_reset();
    test_not_taken();
    test_wrong_target();
    test_taken_not();
    test_false_hit();
    test_stall();
    test_stall_recover();
    test_saturate();
    test_reset_mid_recover();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
